// File: rtl/noc_async_fifo_wr_pkg.sv
// noc_async_fifo_wr_pkg: sizes and Gray helpers shared by both
// endpoints of the NoC async FIFO.
package noc_async_fifo_wr_pkg;

  localparam int NOC_ASYNC_FIFO_PACKET_SIZE = 16;
  localparam int NOC_ASYNC_FIFO_AWIDTH      = 3;

  localparam int PS    = NOC_ASYNC_FIFO_PACKET_SIZE;
  localparam int AW    = NOC_ASYNC_FIFO_AWIDTH;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  // Gray pattern of a pointer sitting exactly one lap ahead
  localparam logic [PW-1:0] FULL_MASK =
    {2'b11, {(PW-2){1'b0}}};

  function automatic logic [PW-1:0] bin2gray(
    input logic [PW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(
    input logic [PW-1:0] g
  );
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Low AW bits of gray2bin(g): bit i is the XOR of g[PW-1:i]
  function automatic logic [AW-1:0] gray2idx(
    input logic [PW-1:0] g
  );
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = ^(g >> i);
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_gray_sync.sv
// noc_gray_sync: multi-flop synchroniser for a Gray-coded
// pointer arriving from another clock domain.
module noc_gray_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stg [STAGES];

  // Shift the foreign pointer through STAGES flops
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign q_o = stg[STAGES-1];

endmodule

// File: rtl/noc_async_fifo_wr.sv
// noc_async_fifo_wr: write-side endpoint of the NoC async FIFO.
// Optional counters: define NOC_AFIFO_WR_STATS_EN.
module noc_async_fifo_wr
  import noc_async_fifo_wr_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [PS-1:0] pkt_data_i,
  input  logic          pkt_valid_i,
  output logic          pkt_ready_o,
  output logic [PS-1:0] noc_fifo_out_data_o,
  output logic [PW-1:0] noc_fifo_out_waddr_o,
  input  logic [PW-1:0] noc_fifo_out_raddr_i,
  output logic [PW-1:0] level_o
`ifdef NOC_AFIFO_WR_STATS_EN
  ,
  output logic [31:0]   stat_pkts_o,
  output logic [31:0]   stat_stall_o
`endif
);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_nxt;
  logic [PW-1:0] rsync;
  logic [PS-1:0] mem [DEPTH];
  logic          full;
  logic          push;

  noc_gray_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_rsync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (noc_fifo_out_raddr_i),
    .q_o     (rsync)
  );

  assign full = noc_fifo_out_waddr_o == (rsync ^ FULL_MASK);
  assign pkt_ready_o = !full;
  assign push = pkt_valid_i && !full;
  assign wbin_nxt = wbin + PW'(1);

  // Advance the binary and published Gray write pointers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wbin                 <= '0;
      noc_fifo_out_waddr_o <= '0;
    end else if (push) begin
      wbin                 <= wbin_nxt;
      noc_fifo_out_waddr_o <= bin2gray(wbin_nxt);
    end
  end

  // Storage array, deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      mem[wbin[AW-1:0]] <= pkt_data_i;
    end
  end

  assign noc_fifo_out_data_o =
    mem[gray2idx(noc_fifo_out_raddr_i)];

  assign level_o = wbin - gray2bin(rsync);

`ifdef NOC_AFIFO_WR_STATS_EN
  // Saturating accepted-packet and stall-cycle counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_pkts_o  <= '0;
      stat_stall_o <= '0;
    end else begin
      if (push && stat_pkts_o != '1) begin
        stat_pkts_o <= stat_pkts_o + 32'd1;
      end
      if (pkt_valid_i && full && stat_stall_o != '1) begin
        stat_stall_o <= stat_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_async_fifo_wr.sv
// tb_noc_async_fifo_wr: directed bench for the async FIFO
// write endpoint (AWIDTH=3, PACKET_SIZE=16).
module tb_noc_async_fifo_wr;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] pkt_data_i;
  logic        pkt_valid_i;
  logic        pkt_ready_o;
  logic [15:0] data_o;
  logic [3:0]  waddr_o;
  logic [3:0]  raddr_i;
  logic [3:0]  level_o;
`ifdef NOC_AFIFO_WR_STATS_EN
  logic [31:0] stat_pkts_o;
  logic [31:0] stat_stall_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [3:0] WEXP [8] = '{
    4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12
  };

  always #5 clk = ~clk;

  noc_async_fifo_wr #(.SYNC_STAGES(2)) dut (
    .clk_i                (clk),
    .reset_i              (reset_i),
    .pkt_data_i           (pkt_data_i),
    .pkt_valid_i          (pkt_valid_i),
    .pkt_ready_o          (pkt_ready_o),
    .noc_fifo_out_data_o  (data_o),
    .noc_fifo_out_waddr_o (waddr_o),
    .noc_fifo_out_raddr_i (raddr_i),
    .level_o              (level_o)
`ifdef NOC_AFIFO_WR_STATS_EN
    ,
    .stat_pkts_o          (stat_pkts_o),
    .stat_stall_o         (stat_stall_o)
`endif
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] gray(input int x);
    logic [3:0] v;
    v = 4'(x);
    return v ^ (v >> 1);
  endfunction

  initial begin
    int pushed;
    int rptr;
    int cyc;
    logic r;
    logic do_push;

    reset_i     = 1'b1;
    pkt_valid_i = 1'b0;
    pkt_data_i  = '0;
    raddr_i     = '0;
    tick();
    tick();
    check("rst_ready", 32'(pkt_ready_o), 32'd1);
    check("rst_waddr", 32'(waddr_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    reset_i = 1'b0;

    // Fill
    for (int i = 0; i < 8; i++) begin
      check("fill_ready", 32'(pkt_ready_o), 32'd1);
      pkt_data_i  = 16'h1000 + 16'(i);
      pkt_valid_i = 1'b1;
      tick();
      check("fill_waddr", 32'(waddr_o), 32'(WEXP[i]));
    end
    check("full_ready", 32'(pkt_ready_o), 32'd0);
    check("full_level", 32'(level_o), 32'd8);
    pkt_data_i = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovf_waddr", 32'(waddr_o), 32'd12);
    end
    pkt_valid_i = 1'b0;
    check("ovf_level", 32'(level_o), 32'd8);
`ifdef NOC_AFIFO_WR_STATS_EN
    check("stat_pkts", stat_pkts_o, 32'd8);
    check("stat_stall", stat_stall_o, 32'd3);
`endif

    // Data lookup (all within one cycle)
    raddr_i = 4'd7;
    #1;
    check("lookup5", 32'(data_o), 32'h1005);
    raddr_i = 4'd0;
    #1;
    check("lookup0", 32'(data_o), 32'h1000);
    raddr_i = 4'd4;
    #1;
    check("lookup7", 32'(data_o), 32'h1007);
    raddr_i = 4'd0;

    // Release
    tick();
    raddr_i = 4'd1;
    tick();
    check("rel_early", 32'(pkt_ready_o), 32'd0);
    tick();
    check("rel_ready", 32'(pkt_ready_o), 32'd1);
    check("rel_level", 32'(level_o), 32'd7);
    pkt_data_i  = 16'h2000;
    pkt_valid_i = 1'b1;
    tick();
    pkt_valid_i = 1'b0;
    check("rel_waddr", 32'(waddr_o), 32'd13);
    check("rel_full", 32'(pkt_ready_o), 32'd0);
    check("rel_level8", 32'(level_o), 32'd8);
    raddr_i = 4'd12;
    #1;
    check("rel_mem0", 32'(data_o), 32'h2000);
    raddr_i = 4'd1;

    // Wrap-around stream with a slow reader
    reset_i = 1'b1;
    raddr_i = '0;
    tick();
    reset_i = 1'b0;
    check("wr_rst_waddr", 32'(waddr_o), 32'd0);
    pushed = 0;
    rptr   = 0;
    cyc    = 0;
    while ((pushed < 40 || rptr < 40) && cyc < 600) begin
      r           = pkt_ready_o;
      pkt_valid_i = (pushed < 40);
      pkt_data_i  = 16'h3000 + 16'(pushed);
      if (cyc % 3 == 0 && rptr < pushed) begin
        check("wr_data", 32'(data_o), 32'h3000 + 32'(rptr));
        rptr++;
        raddr_i = gray(rptr);
      end
      do_push = pkt_valid_i && r;
      tick();
      cyc++;
      if (do_push) begin
        pushed++;
        check("wr_waddr", 32'(waddr_o), 32'(gray(pushed)));
        if (pushed == 15) check("wr_15", 32'(waddr_o), 32'd8);
        if (pushed == 16) check("wr_wrap", 32'(waddr_o), 32'd0);
      end
    end
    pkt_valid_i = 1'b0;
    check("wr_done_rd", 32'(rptr), 32'd40);
    check("wr_done_wr", 32'(pushed), 32'd40);

    // Reset mid-stream
    raddr_i = '0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pkt_data_i  = 16'h4000 + 16'(i);
      pkt_valid_i = 1'b1;
      tick();
    end
    pkt_valid_i = 1'b0;
    tick();
    tick();
    check("mid_level", 32'(level_o), 32'd5);
    check("mid_waddr", 32'(waddr_o), 32'(gray(5)));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("mid_rst_waddr", 32'(waddr_o), 32'd0);
    check("mid_rst_level", 32'(level_o), 32'd0);
    check("mid_rst_ready", 32'(pkt_ready_o), 32'd1);
`ifdef NOC_AFIFO_WR_STATS_EN
    check("mid_rst_pkts", stat_pkts_o, 32'd0);
    check("mid_rst_stall", stat_stall_o, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
